// File: rtl/jar_sram_host_driver_if.sv
// Host request/response bundle for jar_sram_host_driver.
// req_len is present only when SRAM_BURST_EN is defined.
interface jar_sram_host_driver_if #(
  parameter int DW    = 8,
  parameter int ABITS = 3
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [ABITS-1:0] req_addr;
  logic [DW-1:0]    req_wdata;
`ifdef SRAM_BURST_EN
  logic [ABITS-1:0] req_len;
`endif
  logic             rsp_valid;
  logic [DW-1:0]    rsp_data;

`ifdef SRAM_BURST_EN
  modport master (output req_valid, req_we, req_addr, req_wdata, req_len,
                  input  req_ready, rsp_valid, rsp_data);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_len,
                  output req_ready, rsp_valid, rsp_data);
`else
  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_data);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_data);
`endif
endinterface

// File: rtl/jar_sram_host_driver.sv
// Host sequencer for the nibble-serial 8-byte SRAM tile; synthesises the tile pin bus
// {addr_data[3:0], commit, oe, we, clk}. Define SRAM_BURST_EN for streamed burst reads.
module jar_sram_host_driver #(
  parameter int DW          = 8,
  parameter int AW          = 4,
  parameter int ABITS       = 3,
  parameter int HALF_PERIOD = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  jar_sram_host_driver_if.slave host,
  output logic                  busy,
  output logic [DW-1:0]         sram_io_in,
  input  logic [DW-1:0]         sram_io_out
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(2 * HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * HALF_PERIOD - 1);

  // control field order is {commit, oe, we}
  localparam logic [2:0] CTL_WE   = 3'b001;
  localparam logic [2:0] CTL_OE   = 3'b010;
  localparam logic [2:0] CTL_CM   = 3'b100;
  localparam logic [2:0] CTL_SEED = 3'b111;
  localparam logic [2:0] CTL_STRM = 3'b011;

  typedef enum logic [2:0] {
    IDLE, W_LO, W_HI, COMMIT, RD, SAMPLE, SEED, STREAM
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ABITS-1:0] addr_q;
  logic [DW-1:0]    data_q;
  logic             rsp_valid_q;
  logic [DW-1:0]    rsp_data_q;

  logic             accept;
  logic             step_done;
  logic             in_step;
  logic             clk_bit;
  logic [2:0]       ctl;
  logic [AW-1:0]    nib;
  logic             burst_req;
  logic             more;
  logic             in_burst;

`ifdef SRAM_BURST_EN
  logic             burst_q;
  logic [ABITS-1:0] rem_q;

  assign burst_req = !host.req_we && (host.req_len != '0);
  assign more      = burst_q && (rem_q != '0);
  assign in_burst  = burst_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_q <= 1'b0;
      rem_q   <= '0;
    end else if (accept) begin
      burst_q <= burst_req;
      rem_q   <= host.req_len;
    end else if (state_q == SAMPLE && more) begin
      rem_q   <= rem_q - ABITS'(1);
    end
  end
`else
  assign burst_req = 1'b0;
  assign more      = 1'b0;
  assign in_burst  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    ctl       = '0;
    nib       = '0;
    clk_bit   = 1'b0;
    in_step   = 1'b0;
    accept    = 1'b0;
    step_done = (cnt_q == CNT_LAST);
    unique case (state_q)
      IDLE: begin
        accept = host.req_valid;
        if (host.req_valid)
          state_d = host.req_we ? W_LO : (burst_req ? SEED : RD);
      end
      W_LO: begin
        in_step = 1'b1;
        ctl     = CTL_WE;
        nib     = data_q[AW-1:0];
        if (step_done) state_d = W_HI;
      end
      W_HI: begin
        in_step = 1'b1;
        ctl     = CTL_WE;
        nib     = data_q[DW-1:AW];
        if (step_done) state_d = COMMIT;
      end
      COMMIT: begin
        in_step = 1'b1;
        ctl     = CTL_CM;
        nib     = AW'(addr_q);
        if (step_done) state_d = IDLE;
      end
      RD: begin
        in_step = 1'b1;
        ctl     = CTL_OE;
        nib     = AW'(addr_q);
        if (step_done) state_d = SAMPLE;
      end
      SAMPLE: begin
        // single-cycle capture window: oe stays high, tile clock held low
        ctl     = in_burst ? CTL_STRM : CTL_OE;
        nib     = in_burst ? '0 : AW'(addr_q);
        state_d = more ? STREAM : IDLE;
      end
      SEED: begin
        in_step = 1'b1;
        ctl     = CTL_SEED;
        nib     = AW'(addr_q);
        if (step_done) state_d = STREAM;
      end
      STREAM: begin
        in_step = 1'b1;
        ctl     = CTL_STRM;
        if (step_done) state_d = SAMPLE;
      end
      default: state_d = IDLE;
    endcase
    if (in_step) begin
      clk_bit = (cnt_q >= CNT_HALF);
      cnt_d   = step_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (accept) begin
        addr_q <= host.req_addr;
        data_q <= host.req_wdata;
      end
      rsp_valid_q <= (state_q == SAMPLE);
      if (state_q == SAMPLE) rsp_data_q <= sram_io_out;
    end
  end

  assign sram_io_in     = {nib, ctl, clk_bit};
  assign host.req_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jar_sram_host_driver.sv
// Scoreboard bench for jar_sram_host_driver: two instances (HALF_PERIOD 1 and 3),
// each attached to a behavioural SRAM tile.
`timescale 1ns/1ps
module tb_jar_sram_host_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]      vld;
  logic            b_we;
  logic [2:0]      b_addr, b_len;
  logic [7:0]      b_wdata;
  logic [1:0]      rdy_w, rv_w, busy_w;
  logic [1:0][7:0] pins_w, rd_w;

  typedef struct packed {
    logic [7:0] pins;
    logic       rdy;
    logic       rv;
    logic       dchk;
    logic [7:0] data;
  } pexp_t;

  pexp_t      pinq[$];
  logic [7:0] expq0[$];
  logic [7:0] expq1[$];
  pexp_t      pe;
  logic [7:0] exp_b;
  int         cmp = 0;
  int         err = 0;
  int         timeouts = 0;
  logic       done = 1'b0;

  logic [7:0] tbl [8] = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h3E, 8'h81, 8'h7D};

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int HP = (g == 0) ? 1 : 3;
    jar_sram_host_driver_if #(.DW(8), .ABITS(3)) ifc ();
    logic [7:0] pins, tile_out;
    logic       busy;

    assign ifc.req_valid = vld[g];
    assign ifc.req_we    = b_we;
    assign ifc.req_addr  = b_addr;
    assign ifc.req_wdata = b_wdata;
`ifdef SRAM_BURST_EN
    assign ifc.req_len   = b_len;
`endif

    jar_sram_host_driver #(.DW(8), .AW(4), .ABITS(3), .HALF_PERIOD(HP)) dut (
      .clk(clk), .reset(reset), .host(ifc.slave), .busy(busy),
      .sram_io_in(pins), .sram_io_out(tile_out)
    );

    // behavioural tile: acts on 0->1 of pin[0], sampled once per driver cycle
    logic [7:0] mem [8];
    logic [7:0] wbuf = 8'h00;
    logic [2:0] raddr = 3'd0;
    logic [2:0] sidx = 3'd0;
    logic       prev_clk = 1'b0;
    always @(negedge clk) begin
      prev_clk <= pins[0];
      if (!prev_clk && pins[0]) begin
        if (pins[3:1] == 3'b001)      wbuf <= {pins[7:4], wbuf[7:4]};
        else if (pins[3:1] == 3'b100) mem[pins[6:4]] <= wbuf;
        else if (pins[3:1] == 3'b010) raddr <= pins[6:4];
        else if (pins[3:1] == 3'b111) sidx <= pins[6:4];
        else if (pins[3:1] == 3'b011) begin raddr <= sidx; sidx <= sidx + 3'd1; end
      end
    end
    assign tile_out = pins[2] ? mem[raddr] : 8'h00;

    assign pins_w[g] = pins;
    assign rdy_w[g]  = ifc.req_ready;
    assign rv_w[g]   = ifc.rsp_valid;
    assign rd_w[g]   = ifc.rsp_data;
    assign busy_w[g] = busy;
  end

  always @(negedge clk) begin
    if (pinq.size() != 0) begin
      pe = pinq.pop_front();
      cmp++;
      if (pins_w[0] !== pe.pins || rdy_w[0] !== pe.rdy || busy_w[0] !== !pe.rdy ||
          rv_w[0] !== pe.rv || (pe.dchk && rd_w[0] !== pe.data)) begin
        err++;
        $display("FAIL pins t=%0t: got pins=%02h rdy=%b busy=%b rv=%b data=%02h, want pins=%02h rdy=%b busy=%b rv=%b data=%02h",
                 $time, pins_w[0], rdy_w[0], busy_w[0], rv_w[0], rd_w[0],
                 pe.pins, pe.rdy, !pe.rdy, pe.rv, pe.data);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rv_w[k]) begin
        cmp++;
        if ((k == 0 && expq0.size() == 0) || (k == 1 && expq1.size() == 0)) begin
          err++;
          $display("FAIL rsp%0d t=%0t: unexpected pulse data=%02h, want no response", k, $time, rd_w[k]);
        end else begin
          if (k == 0) exp_b = expq0.pop_front();
          else        exp_b = expq1.pop_front();
          if (rd_w[k] !== exp_b) begin
            err++;
            $display("FAIL rsp%0d t=%0t: data=%02h, want %02h", k, $time, rd_w[k], exp_b);
          end
        end
      end
    end
    if (done) begin
      cmp++;
      if (timeouts != 0 || expq0.size() != 0 || expq1.size() != 0 || pinq.size() != 0) begin
        err++;
        $display("FAIL drain: timeouts=%0d pending=%0d/%0d/%0d, want 0/0/0/0",
                 timeouts, expq0.size(), expq1.size(), pinq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
    end
  end

  task automatic px(input logic [7:0] p, input logic r, input logic v);
    pexp_t e;
    e.pins = p; e.rdy = r; e.rv = v; e.dchk = 1'b0; e.data = 8'h00;
    pinq.push_back(e);
  endtask

  task automatic px_rst();
    pexp_t e;
    e.pins = 8'h00; e.rdy = 1'b1; e.rv = 1'b0; e.dchk = 1'b1; e.data = 8'h00;
    pinq.push_back(e);
  endtask

  task automatic issue(input int s, input logic we, input logic [2:0] a,
                       input logic [7:0] d, input logic [2:0] l);
    int   n  = 0;
    logic ok = 1'b0;
    b_we = we; b_addr = a; b_wdata = d; b_len = l;
    vld = 2'b00; vld[s] = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk); ok = rdy_w[s];
      @(posedge clk); #1; n++;
    end
    vld = 2'b00;
    if (!ok) begin
      timeouts++;
      $display("FAIL issue inst%0d addr %0d: not accepted, want acceptance", s, a);
    end
  endtask

  task automatic wr(input int s, input logic [2:0] a, input logic [7:0] d);
    issue(s, 1'b1, a, d, 3'd0);
  endtask

  task automatic rd(input int s, input logic [2:0] a, input logic [7:0] e);
    if (s == 0) expq0.push_back(e);
    else        expq1.push_back(e);
    issue(s, 1'b0, a, 8'h00, 3'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(rdy_w == 2'b11 && expq0.size() == 0 && expq1.size() == 0 && pinq.size() == 0) && n < 400);
    if (n >= 400) begin
      timeouts++;
      $display("FAIL wait_idle: still busy after %0d cycles, want idle", n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; vld = 2'b00; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_len = '0;
    px_rst();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_idle();

    // write 0xA5 @3, pin-exact
    px(8'h00, 1, 0); px(8'h52, 0, 0); px(8'h53, 0, 0); px(8'hA2, 0, 0);
    px(8'hA3, 0, 0); px(8'h38, 0, 0); px(8'h39, 0, 0); px(8'h00, 1, 0);
    wr(0, 3'd3, 8'hA5);
    wait_idle();

    // read @3, pin-exact
    px(8'h00, 1, 0); px(8'h34, 0, 0); px(8'h35, 0, 0); px(8'h34, 0, 0);
    px(8'h00, 1, 1); px(8'h00, 1, 0);
    rd(0, 3'd3, 8'hA5);
    wait_idle();

    // full fill and reverse readback on both instances
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) wr(s, 3'(i), tbl[i]);
      for (int i = 7; i >= 0; i--) rd(s, 3'(i), tbl[i]);
      wait_idle();
    end

    // back-to-back reads with req_valid held high
    px(8'h00, 1, 0); px(8'h14, 0, 0); px(8'h15, 0, 0); px(8'h14, 0, 0);
    px(8'h00, 1, 1); px(8'h24, 0, 0); px(8'h25, 0, 0); px(8'h24, 0, 0);
    px(8'h00, 1, 1); px(8'h00, 1, 0);
    rd(0, 3'd1, tbl[1]);
    rd(0, 3'd2, tbl[2]);
    wait_idle();

    // reset during W_HI of write 0x11 @2 leaves prior 0x77 intact
    wr(0, 3'd2, 8'h77);
    wait_idle();
    wr(0, 3'd2, 8'h11);
    px(8'h12, 0, 0); px(8'h13, 0, 0);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    px_rst();
    @(posedge clk); #1 reset = 1'b0;
    wait_idle();
    rd(0, 3'd2, 8'h77);
    wait_idle();

`ifdef SRAM_BURST_EN
    // burst read @6 len=2 wraps 7->0
    wr(0, 3'd6, 8'h66); wr(0, 3'd7, 8'h77); wr(0, 3'd0, 8'h00);
    wait_idle();
    px(8'h00, 1, 0); px(8'h6E, 0, 0); px(8'h6F, 0, 0);
    px(8'h06, 0, 0); px(8'h07, 0, 0); px(8'h06, 0, 0);
    px(8'h06, 0, 1); px(8'h07, 0, 0); px(8'h06, 0, 0);
    px(8'h06, 0, 1); px(8'h07, 0, 0); px(8'h06, 0, 0);
    px(8'h00, 1, 1); px(8'h00, 1, 0);
    expq0.push_back(8'h66); expq0.push_back(8'h77); expq0.push_back(8'h00);
    issue(0, 1'b0, 3'd6, 8'h00, 3'd2);
    wait_idle();
`endif

    done = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

endmodule
